fomo_input_stage: RTL and testbench
===================================

FOMO_INPUT_STAGE -- requirements
Module: fomo_input_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, using the port names clk and rst_n.
REQ-002 The block SHALL have these ports: clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ena  input  1  design-selected enable; high permits capture.
REQ-005 data_in  input  8  command byte (driven from ui_in); asynchronous to clk.
REQ-006 strobe_in  input  1  write strobe (driven from uio_in[0]); asynchronous, rising edge marks a byte.
REQ-007 out_data  output  8  FIFO head byte (show-ahead).
REQ-008 out_valid  output  1  FIFO not empty.
REQ-009 out_ready  input  1  core accepts the head byte this cycle.
REQ-010 level  output  3  occupancy, range 0..4.
REQ-011 full  output  1  level == 4.
REQ-012 overflow  output  1  sticky dropped-byte flag (see Configuration).

Function
REQ-013 strobe_in SHALL pass through a 2-flop synchronizer followed by a third history flop; edge = sync2 & ~sync3.
REQ-014 On a cycle with edge high and ena high, the block SHALL push data_in, sampled on that same clock edge, into a 4-entry FIFO; data_in is required to be stable for at least 3 clk cycles before and 1 clk cycle after the strobe_in rise.
REQ-015 Latency: strobe_in rising before clock edge N SHALL push on edge N+2, with out_valid high after edge N+2 when the FIFO was empty.
REQ-016 Pop SHALL occur on any edge where out_valid && out_ready; out_ready while empty SHALL be ignored.
REQ-017 A push SHALL be accepted when level < 4, or when level == 4 and a pop occurs on the same edge.
REQ-018 A push with level == 4 and no pop SHALL be dropped; FIFO contents and pointers SHALL stay unchanged.
REQ-019 Simultaneous push and pop SHALL leave level unchanged and advance both pointers.
REQ-020 Read and write pointers SHALL be 2 bits and wrap 3 -> 0; level SHALL be tracked separately to distinguish full from empty.
REQ-021 out_data SHALL equal the head entry when out_valid is high, and 8'h00 when empty.
REQ-022 With ena low, edges SHALL be ignored (no push); the synchronizer, pops and outputs SHALL continue to operate.
REQ-023 The block SHALL capture one byte per strobe_in rising edge; a held-high strobe SHALL NOT repeat captures.

Reset
REQ-024 While rst_n is low, the block SHALL asynchronously clear all synchronizer flops, pointers, level and the overflow flag to 0.
REQ-025 The reset values SHALL be out_valid=0, out_data=8'h00, level=0, full=0 and overflow=0, including when reset is asserted mid-operation with data queued.
REQ-026 After rst_n deasserts with strobe_in already high, no push SHALL occur until strobe_in goes low and then high again.

Configuration
REQ-027 The macro FOMO_OVERFLOW_FLAG_EN SHALL select the overflow behaviour.
REQ-028 With FOMO_OVERFLOW_FLAG_EN defined, overflow SHALL go to 1 on the edge after a push is dropped (REQ-018) and stay set until reset.
REQ-029 Without FOMO_OVERFLOW_FLAG_EN, overflow SHALL be tied to 0 and no flag register SHALL exist; drop behaviour SHALL be unchanged.

Verification
REQ-030 The bench SHALL cover single byte: data_in=8'hA5 with one strobe pulse and out_ready=0 -> out_valid=1 and out_data=8'hA5 exactly 3 edges after the strobe rise, with level=1.
REQ-031 The bench SHALL cover fill and drop: 5 strobes of 8'h01..8'h05 with out_ready=0 -> level=4, full=1, popping yields 01,02,03,04, and overflow=1 only if the macro is defined.
REQ-032 The bench SHALL cover full with simultaneous pop: with level=4, out_ready=1 on the push edge of 8'h55 -> level stays 4 and 8'h55 emerges last.
REQ-033 The bench SHALL cover ena gating: ena=0 and 2 strobes -> level stays 0; then ena=1 and 1 strobe -> level=1.
REQ-034 The bench SHALL cover wrap-around: 10 push/pop pairs of 8'h10..8'h19 -> output order is preserved and level ends at 0.
REQ-035 The bench SHALL cover mid-operation reset: with level=3, pulse rst_n low for 1 ns between edges -> out_valid=0 and level=0 immediately, and the next strobe gives level=1.

Source files
------------

// File: rtl/fomo_input_stage.sv
// Strobe-synchronized command byte capture into a 4-entry show-ahead FIFO.
// Optional sticky overflow flag enabled by defining FOMO_OVERFLOW_FLAG_EN.
module fomo_input_stage (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] data_in,
    input  logic       strobe_in,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] level,
    output logic       full,
    output logic       overflow
);

    logic       sync1_q, sync2_q, sync3_q;
    logic       primed_q, armed_q;
    logic       edge_det, push_req, push, pop;
    logic [7:0] mem_q [4];
    logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0] level_q, level_d;

    // armed_q only sets once the chain has seen strobe low after reset, so a
    // strobe already high at reset release cannot look like a fresh rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync3_q  <= 1'b0;
            primed_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            sync1_q  <= strobe_in;
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            primed_q <= 1'b1;
            armed_q  <= armed_q | (primed_q & ~sync1_q);
        end
    end

    assign edge_det = sync2_q & ~sync3_q & armed_q;
    assign push_req = edge_det & ena;
    assign pop      = out_valid & out_ready;
    assign push     = push_req & ((level_q != 3'd4) | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + 2'd1;
        if (pop)  rd_ptr_d = rd_ptr_q + 2'd1;
        case ({push, pop})
            2'b10:   level_d = level_q + 3'd1;
            2'b01:   level_d = level_q - 3'd1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            level_q  <= 3'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: empty FIFO masks the head to zero.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

    assign out_valid = (level_q != 3'd0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign level     = level_q;
    assign full      = (level_q == 3'd4);

`ifdef FOMO_OVERFLOW_FLAG_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_q | (push_req & ~push);
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_fomo_input_stage.sv
// Scoreboard bench for fomo_input_stage: directed strobes, queue of expected
// bytes checked by an independent monitor on every accepted pop.
module tb_fomo_input_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       strobe_in = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] level;
    logic       full;
    logic       overflow;

    int n_chk = 0;
    int n_pass = 0;
    logic [7:0] exp_q [$];
    logic exp_ovf;

    fomo_input_stage dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in),
        .strobe_in(strobe_in), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .level(level), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: any pop the DUT will take on the next edge is checked here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL pop_unexpected: got %0h expected none", out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_data == e) n_pass++;
                else $display("FAIL pop_data: got %0h expected %0h", out_data, e);
            end
        end
    end

    // Byte setup, strobe rise just before edge N, push lands on edge N+2.
    task automatic send(input logic [7:0] d, input bit expect_push);
        data_in = d;
        repeat (3) tick();
        strobe_in = 1'b1;
        if (expect_push) exp_q.push_back(d);
        repeat (3) tick();
        strobe_in = 1'b0;
        repeat (2) tick();
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        out_ready = 1'b1;
        while (out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        chk({name, "_drain_lvl"}, level, 0);
        chk({name, "_empty_data"}, out_data, 8'h00);
    endtask

    initial begin
`ifdef FOMO_OVERFLOW_FLAG_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        repeat (2) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 8'h00);
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // single byte: valid appears exactly on the third edge after the rise
        data_in = 8'hA5;
        repeat (3) tick();
        strobe_in = 1'b1;
        exp_q.push_back(8'hA5);
        tick();
        chk("single_n0_valid", out_valid, 0);
        tick();
        chk("single_n1_valid", out_valid, 0);
        tick();
        chk("single_n2_valid", out_valid, 1);
        chk("single_n2_data", out_data, 8'hA5);
        chk("single_level", level, 1);
        repeat (4) tick();
        chk("single_held_level", level, 1);
        strobe_in = 1'b0;
        repeat (2) tick();
        drain("single");

        // fill and drop
        for (int i = 1; i <= 5; i++) send(8'(i), i <= 4);
        chk("fill_level", level, 4);
        chk("fill_full", full, 1);
        chk("fill_ovf", overflow, int'(exp_ovf));

        // full with pop on the push edge of 8'h55
        data_in = 8'h55;
        repeat (3) tick();
        strobe_in = 1'b1;
        exp_q.push_back(8'h55);
        repeat (2) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("simul_level", level, 4);
        chk("simul_head", out_data, 8'h02);
        strobe_in = 1'b0;
        repeat (2) tick();
        drain("simul");

        // ena gating
        ena = 1'b0;
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        chk("ena0_level", level, 0);
        ena = 1'b1;
        send(8'h77, 1'b1);
        chk("ena1_level", level, 1);
        drain("ena");

        // wrap-around
        for (int i = 0; i < 10; i++) begin
            send(8'h10 + 8'(i), 1'b1);
            drain("wrap");
        end

        // mid-operation reset
        send(8'h31, 1'b1);
        send(8'h32, 1'b1);
        send(8'h33, 1'b1);
        chk("mid_level3", level, 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_data", out_data, 8'h00);
        chk("mid_rst_ovf", overflow, 0);
        rst_n = 1'b1;
        exp_q.delete();
        tick();
        send(8'h3C, 1'b1);
        chk("mid_after_level", level, 1);
        drain("mid");

        // reset released with strobe already high
        data_in = 8'hEE;
        strobe_in = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        repeat (6) tick();
        chk("held_strobe_level", level, 0);
        strobe_in = 1'b0;
        repeat (2) tick();
        send(8'h5A, 1'b1);
        chk("rearm_level", level, 1);
        drain("rearm");

        chk("sb_leftover", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
